closest_hit_select: RTL

//  Downstream of the per-triangle intersection stage. Consumes one intersection result per triangle,

---
 rtl/closest_hit_select.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/closest_hit_select.sv
// ============================================================================
// Module   : closest_hit_select
// Brief    : Tracks the nearest qualifying ray/triangle hit (smallest signed
//            Q16.16 t) across a ray's beats and emits one closest-hit record.
//            Optional macro CLOSEST_HIT_COUNT_EN adds the o_hit_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module closest_hit_select #(
  parameter int                 IDX_W = 16,
  parameter logic signed [31:0] T_MAX = 32'sh7FFFFFFF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_last,
  input  logic [IDX_W-1:0]        i_tri_id,
  input  logic                    i_hit,
  input  logic                    i_invalid,
  input  logic signed [31:0]      i_t,
  input  logic [0:2][31:0]        i_normal,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_hit,
  output logic [IDX_W-1:0]        o_tri_id,
  output logic signed [31:0]      o_t,
  output logic [0:2][31:0]        o_normal,
  output logic                    o_any_invalid
`ifdef CLOSEST_HIT_COUNT_EN
  ,
  output logic [IDX_W:0]          o_hit_count
`endif
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_EMIT  = 1'b1;

  logic [0:0]          r_state;
  logic                r_best_hit;
  logic [IDX_W-1:0]    r_best_id;
  logic signed [31:0]  r_best_t;
  logic [0:2][31:0]    r_best_normal;
  logic                r_any_inv;

  logic                w_accept;
  logic                w_qual;
  logic                w_take;
  logic                w_nxt_hit;
  logic [IDX_W-1:0]    w_nxt_id;
  logic signed [31:0]  w_nxt_t;
  logic [0:2][31:0]    w_nxt_normal;
  logic                w_nxt_inv;

  assign o_ready  = (r_state == S_ACCUM);
  assign o_valid  = (r_state == S_EMIT);
  assign w_accept = i_valid && o_ready;
  assign w_qual   = i_hit && !i_invalid;
  // Strict less-than keeps the earlier triangle on equal distance.
  assign w_take   = w_accept && w_qual && (!r_best_hit || ($signed(i_t) < $signed(r_best_t)));

  assign w_nxt_hit    = w_take ? 1'b1       : r_best_hit;
  assign w_nxt_id     = w_take ? i_tri_id   : r_best_id;
  assign w_nxt_t      = w_take ? i_t        : r_best_t;
  assign w_nxt_normal = w_take ? i_normal   : r_best_normal;
  assign w_nxt_inv    = r_any_inv | (w_accept & i_invalid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_ACCUM;
      r_best_hit    <= 1'b0;
      r_best_id     <= '0;
      r_best_t      <= T_MAX;
      r_best_normal <= '0;
      r_any_inv     <= 1'b0;
      o_hit         <= 1'b0;
      o_tri_id      <= '0;
      o_t           <= T_MAX;
      o_normal      <= '0;
      o_any_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_best_hit    <= w_nxt_hit;
            r_best_id     <= w_nxt_id;
            r_best_t      <= w_nxt_t;
            r_best_normal <= w_nxt_normal;
            r_any_inv     <= w_nxt_inv;
            if (i_last) begin
              o_hit         <= w_nxt_hit;
              o_tri_id      <= w_nxt_id;
              o_t           <= w_nxt_t;
              o_normal      <= w_nxt_normal;
              o_any_invalid <= w_nxt_inv;
              r_state       <= S_EMIT;
            end
          end
        end
        default: begin
          // Record stays frozen until the shading stage takes it.
          if (i_ready) begin
            r_best_hit    <= 1'b0;
            r_best_id     <= '0;
            r_best_t      <= T_MAX;
            r_best_normal <= '0;
            r_any_inv     <= 1'b0;
            r_state       <= S_ACCUM;
          end
        end
      endcase
    end
  end

`ifdef CLOSEST_HIT_COUNT_EN
  logic [IDX_W:0] r_cnt;
  logic [IDX_W:0] w_nxt_cnt;

  assign w_nxt_cnt = (w_accept && w_qual && (r_cnt != '1)) ? (r_cnt + {{IDX_W{1'b0}}, 1'b1}) : r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      o_hit_count <= '0;
    end else if (r_state == S_ACCUM) begin
      if (w_accept) begin
        r_cnt <= w_nxt_cnt;
        if (i_last) begin
          o_hit_count <= w_nxt_cnt;
        end
      end
    end else if (i_ready) begin
      r_cnt <= '0;
    end
  end
`endif

endmodule

`default_nettype wire
